vie_inst_sram_resp: RTL and testbench

//  Responder end of the instruction-SRAM bus driven by the fetch stage.

---
 rtl/vie_inst_sram_resp.sv | 108 ++++++++++
 tb/tb_vie_inst_sram_resp.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vie_inst_sram_resp.sv
// Instruction-SRAM responder with loader preload port and sticky out-of-range error capture.
// Read data returns one cycle after en and is held while en is low; there is no back-pressure, so a request is accepted every cycle.
module vie_inst_sram_resp #(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE_PA    = 32'h1fc0_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [68:0] inst_ifc_i,
    output logic [31:0] ifc_inst_o,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    input  logic        err_clr,
    output logic        err_oob,
    output logic [31:0] err_addr
);

    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [31:0] PA_MASK = 32'h1fff_ffff;

    logic [31:0] mem_q [DEPTH];

    logic        f_en;
    logic [3:0]  f_wen;
    logic [31:0] f_addr;
    logic [31:0] f_wdata;

    assign f_en    = inst_ifc_i[68];
    assign f_wen   = inst_ifc_i[67:64];
    assign f_addr  = inst_ifc_i[63:32];
    assign f_wdata = inst_ifc_i[31:0];

    logic [31:0] f_pa, f_off, ld_pa, ld_off;
    logic        f_in_range, ld_in_range;
    logic [DEPTH_LOG2-1:0] f_idx, ld_idx;

    // Physical address below BASE_PA wraps the offset to a huge value, so it
    // falls out of range rather than aliasing into the store.
    assign f_pa        = f_addr & PA_MASK;
    assign f_off       = f_pa - BASE_PA;
    assign f_in_range  = (f_pa >= BASE_PA) && ((f_off >> 2) < 32'(DEPTH));
    assign f_idx       = f_off[DEPTH_LOG2+1:2];

    assign ld_pa       = ld_addr & PA_MASK;
    assign ld_off      = ld_pa - BASE_PA;
    assign ld_in_range = (ld_pa >= BASE_PA) && ((ld_off >> 2) < 32'(DEPTH));
    assign ld_idx      = ld_off[DEPTH_LOG2+1:2];

    logic f_we, ld_we, f_blocked;

    assign f_we      = f_en && (f_wen != 4'b0000) && f_in_range;
    assign ld_we     = ld_valid && ld_in_range;
    assign f_blocked = ld_we && (ld_idx == f_idx);

    // Store is deliberately not reset; loader takes the whole word on a collision.
    always_ff @(posedge clock) begin
        if (f_we && !f_blocked) begin
            for (int k = 0; k < 4; k++) begin
                if (f_wen[k]) begin
                    mem_q[f_idx][8*k +: 8] <= f_wdata[8*k +: 8];
                end
            end
        end
        if (ld_we) begin
            mem_q[ld_idx] <= ld_data;
        end
    end

    logic [31:0] rdata_q, rdata_d;
    logic        err_oob_q, err_oob_d;
    logic [31:0] err_addr_q, err_addr_d;

    always_comb begin
        rdata_d    = rdata_q;
        err_oob_d  = err_oob_q;
        err_addr_d = err_addr_q;
        if (f_en) begin
            rdata_d = f_in_range ? mem_q[f_idx] : 32'h0000_0000;
        end
        // A new error in the same cycle as a clear re-arms capture of the new address.
        if (f_en && !f_in_range) begin
            err_oob_d = 1'b1;
            if (!err_oob_q || err_clr) begin
                err_addr_d = f_addr;
            end
        end else if (err_clr) begin
            err_oob_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata_q    <= 32'h0000_0000;
            err_oob_q  <= 1'b0;
            err_addr_q <= 32'h0000_0000;
        end else begin
            rdata_q    <= rdata_d;
            err_oob_q  <= err_oob_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign ifc_inst_o = rdata_q;
    assign err_oob    = err_oob_q;
    assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_vie_inst_sram_resp.sv
// Directed and randomized checks of vie_inst_sram_resp against an address-arithmetic reference model.
module tb_vie_inst_sram_resp;

    localparam logic [31:0] BASE = 32'h1fc0_0000;
    localparam int          NW   = 4096;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [68:0] inst_ifc_i = '0;
    logic [31:0] ifc_inst_o;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic        err_clr = 1'b0;
    logic        err_oob;
    logic [31:0] err_addr;

    always #5 clock = ~clock;

    vie_inst_sram_resp dut (
        .clock      (clock),
        .reset      (reset),
        .inst_ifc_i (inst_ifc_i),
        .ifc_inst_o (ifc_inst_o),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .err_clr    (err_clr),
        .err_oob    (err_oob),
        .err_addr   (err_addr)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m [NW];
    logic [31:0] exp_inst = '0;
    logic        exp_oob  = 1'b0;
    logic [31:0] exp_addr = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Byte offset from the base as a signed 64-bit value; anything negative or past the store is out of range.
    function automatic bit in_rng(input logic [31:0] a, output int idx);
        longint pa, base_l, off;
        pa     = a & 32'h1fff_ffff;
        base_l = BASE;
        off    = pa - base_l;
        idx    = 0;
        if (off >= 0 && off < 4 * NW) begin
            idx = int'(off / 4);
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic step(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic ldv, input logic [31:0] la,
                        input logic [31:0] ld, input logic clr);
        int fi, li;
        bit fr, lr;
        inst_ifc_i = {en, wen, addr, wdata};
        ld_valid   = ldv;
        ld_addr    = la;
        ld_data    = ld;
        err_clr    = clr;
        fr = in_rng(addr, fi);
        lr = in_rng(la, li);
        if (en) exp_inst = fr ? mem_m[fi] : 32'h0;
        if (en && fr) begin
            for (int k = 0; k < 4; k++)
                if (wen[k]) mem_m[fi][8*k +: 8] = wdata[8*k +: 8];
        end
        if (ldv && lr) mem_m[li] = ld;
        if (en && !fr) begin
            if (!exp_oob || clr) exp_addr = addr;
            exp_oob = 1'b1;
        end else if (clr) begin
            exp_oob = 1'b0;
        end
        @(posedge clock);
        #1;
        chk("inst", ifc_inst_o, exp_inst);
        chk("err_oob", {31'd0, err_oob}, {31'd0, exp_oob});
        chk("err_addr", err_addr, exp_addr);
    endtask

    task automatic ld_word(input logic [31:0] a, input logic [31:0] d);
        step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, a, d, 1'b0);
    endtask

    task automatic rd(input logic [31:0] a);
        step(1'b1, 4'h0, a, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] pa, top, r;
        r = $urandom_range(0, 9);
        if (r < 7) begin
            r  = $urandom_range(0, 16);
            pa = BASE + ((r == 16) ? 32'(NW - 1) : r) * 4;
        end else if (r == 7) begin
            pa = BASE + 32'(4 * NW) + $urandom_range(0, 4000);
        end else if (r == 8) begin
            pa = $urandom_range(0, 32'(BASE) - 1);
        end else begin
            pa = $urandom_range(32'(BASE) + 32'(4 * NW), 32'h1fff_ffff);
        end
        pa[1:0] = 2'($urandom_range(0, 3));
        top = $urandom_range(0, 7);
        return {top[2:0], pa[28:0]};
    endfunction

    initial begin
        logic [31:0] fa, la, r;

        // Reset: all outputs zero and known.
        repeat (3) @(posedge clock);
        #1;
        chk("rst_inst", ifc_inst_o, 32'h0);
        chk("rst_oob", {31'd0, err_oob}, 32'h0);
        chk("rst_eaddr", err_addr, 32'h0);
        chk("rst_noX", {31'd0, $isunknown({ifc_inst_o, err_oob, err_addr})}, 32'h0);
        reset = 1'b1;
        idle();

        // Load via virtual address, read back, hold across stall.
        ld_word(32'hbfc0_0000, 32'h3c08_bfaf);
        rd(32'hbfc0_0000);
        chk("t2_read", ifc_inst_o, 32'h3c08_bfaf);
        repeat (5) idle();
        chk("t2_hold", ifc_inst_o, 32'h3c08_bfaf);

        // Byte-enable write returns the old word.
        ld_word(32'h1fc0_0004, 32'h1122_3344);
        step(1'b1, 4'b0101, 32'h1fc0_0004, 32'haabb_ccdd, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("t3_old", ifc_inst_o, 32'h1122_3344);
        rd(32'h1fc0_0004);
        chk("t3_new", ifc_inst_o, 32'h11bb_33dd);

        // Out-of-range capture, sticky address, clear plus new error.
        rd(32'hbfc0_4000);
        chk("t4_nop", ifc_inst_o, 32'h0);
        chk("t4_eaddr", err_addr, 32'hbfc0_4000);
        rd(32'h0000_0000);
        chk("t4_sticky", err_addr, 32'hbfc0_4000);
        step(1'b1, 4'h0, 32'hbfc0_8000, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("t4_clr_new", err_addr, 32'hbfc0_8000);
        chk("t4_clr_oob", {31'd0, err_oob}, 32'h1);
        step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("t4_cleared", {31'd0, err_oob}, 32'h0);

        // Loader and fetch collide on one word.
        ld_word(32'hbfc0_0010, 32'h0);
        step(1'b1, 4'hf, 32'hbfc0_0010, 32'h1234_5678, 1'b1, 32'hbfc0_0010, 32'hdead_beef, 1'b0);
        chk("t5_old", ifc_inst_o, 32'h0);
        rd(32'hbfc0_0010);
        chk("t5_ld_wins", ifc_inst_o, 32'hdead_beef);

        // Reset between request and return edge.
        rd(32'hbfc0_0000);
        inst_ifc_i = {1'b1, 4'h0, 32'hbfc0_0004, 32'h0};
        #3;
        reset = 1'b0;
        #1;
        chk("t6_async", ifc_inst_o, 32'h0);
        @(posedge clock);
        #1;
        chk("t6_inrst", ifc_inst_o, 32'h0);
        reset = 1'b1;
        exp_inst = '0;
        exp_oob  = 1'b0;
        exp_addr = '0;
        idle();
        idle();
        rd(32'hbfc0_0000);
        chk("t6_kept", ifc_inst_o, 32'h3c08_bfaf);

        // Randomized traffic over a preloaded window plus the last word.
        for (int i = 0; i < 16; i++) ld_word(32'h9fc0_0000 + 32'(i * 4), $urandom);
        ld_word(BASE + 32'(4 * (NW - 1)), $urandom);
        for (int i = 0; i < 400; i++) begin
            fa = rand_addr();
            la = ($urandom_range(0, 3) == 0) ? fa : rand_addr();
            r  = $urandom;
            step(r[0] | r[1], (r[2] ? 4'($urandom) : 4'h0), fa, $urandom,
                 r[3] & r[4], la, $urandom, (r[7:5] == 3'b000));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
